// File: rtl/gpio_in_debounce_pkg.sv
// Shared constants and helpers for the GPIO input debounce block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_in_debounce_pkg;

   // 8 user switches + 5 joystick + 3 selection switches + 1 microSD detect
   localparam int GPIO_IN_WIDTH       = 17;
   localparam int DEBOUNCE_DEFAULT_US = 5000;
   localparam int SYS_CLK_DEFAULT_HZ  = 40_000_000;
   localparam int SYNC_STAGES_DEFAULT = 2;

   // Number of clk cycles an input must hold a new level before it is accepted.
   function automatic int debounce_cycles(input int freq_hz, input int us);
      return (freq_hz / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Level/pulse bundle between raw pins and the debounced GPIO input bus.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
//  in_i      raw pin levels (polarity already corrected)
//  bypass_i  1: output follows synchronised input without filtering
//  out_o     debounced level; rise_o/fall_o per-bit edge pulses; changed_o any edge
interface gpio_in_debounce_if #(
   parameter int WIDTH = 17
);
   logic [WIDTH-1:0] in_i;
   logic             bypass_i;
   logic [WIDTH-1:0] out_o;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;
   logic             changed_o;

   // master: the side that owns the pins; slave: the debounce block
   modport master (
      output in_i, bypass_i,
      input  out_o, rise_o, fall_o, changed_o
   );
   modport slave (
      input  in_i, bypass_i,
      output out_o, rise_o, fall_o, changed_o
   );
endinterface

// File: rtl/gpio_in_debounce_cell.sv
// One-bit synchroniser + stability counter + output flop with registered edge pulses.
// Latency: SyncStages + DebounceCycles cycles for a clean step (SyncStages + 1 in bypass).
// Backpressure: none.
//  i_in raw bit, i_bypass skip filter, o_out debounced level, o_rise/o_fall pulses,
//  o_edge_nxt combinational "an edge is being registered this cycle" for the aggregate pulse.
module gpio_in_debounce_cell #(
   parameter int   SyncStages     = 2,
   parameter int   DebounceCycles = 4,
   parameter int   CntW           = 3,
   parameter logic ResetValue     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_in,
   input  logic i_bypass,
   output logic o_out,
   output logic o_rise,
   output logic o_fall,
   output logic o_edge_nxt
);

   logic [SyncStages-1:0] r_sync;
   logic [CntW-1:0]       r_cnt;
   logic                  r_out;
   logic                  r_rise;
   logic                  r_fall;

   logic w_sync;
   logic w_mismatch;
   logic w_accept;

   assign w_sync     = r_sync[SyncStages-1];
   assign w_mismatch = (w_sync != r_out);
   // The new level is taken once it has differed for DebounceCycles cycles in a row,
   // or immediately when the filter is bypassed.
   assign w_accept   = w_mismatch && (i_bypass || (r_cnt == CntW'(DebounceCycles - 1)));
   assign o_edge_nxt = w_accept && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= {SyncStages{ResetValue}};
         r_out  <= ResetValue;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], i_in};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_accept) begin
            r_out  <= w_sync;
            r_cnt  <= '0;
            r_rise <= w_sync;
            r_fall <= !w_sync;
         end else if (w_mismatch && !i_bypass) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            // Any matching cycle (or bypass) throws the partial count away.
            r_cnt <= '0;
         end
      end
   end

   assign o_out  = r_out;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounces Width board switch/detect inputs; per-bit level + edge pulses, aggregate change pulse.
// Latency: SyncStages + DebounceCycles cycles from a clean pin step to out_o (SyncStages+1 bypassed).
// Backpressure: none; outputs are always valid after reset.
//  clk_i system clock, rst_i synchronous active-high reset, bus slave modport (in_i, bypass_i
//  in; out_o, rise_o, fall_o, changed_o out).
module gpio_in_debounce
   import gpio_in_debounce_pkg::*;
#(
   parameter int               Width      = GPIO_IN_WIDTH,
   parameter int               SysClkFreq = SYS_CLK_DEFAULT_HZ,
   parameter int               DebounceUs = DEBOUNCE_DEFAULT_US,
   parameter int               SyncStages = SYNC_STAGES_DEFAULT,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   gpio_in_debounce_if.slave bus
);

   localparam int DebounceCycles = debounce_cycles(SysClkFreq, DebounceUs);
   localparam int CntW           = $clog2(DebounceCycles + 1);

   if (DebounceCycles < 1) begin : g_bad_cycles
      $error("gpio_in_debounce: DebounceCycles must be >= 1");
   end
   if (SyncStages < 2) begin : g_bad_sync
      $error("gpio_in_debounce: SyncStages must be >= 2");
   end

   logic [Width-1:0] w_out;
   logic [Width-1:0] w_rise;
   logic [Width-1:0] w_fall;
   logic [Width-1:0] w_edge_nxt;
   logic             r_changed;

   for (genvar g = 0; g < Width; g++) begin : g_cell
      gpio_in_debounce_cell #(
         .SyncStages     (SyncStages),
         .DebounceCycles (DebounceCycles),
         .CntW           (CntW),
         .ResetValue     (ResetValue[g])
      ) u_cell (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .i_in       (bus.in_i[g]),
         .i_bypass   (bus.bypass_i),
         .o_out      (w_out[g]),
         .o_rise     (w_rise[g]),
         .o_fall     (w_fall[g]),
         .o_edge_nxt (w_edge_nxt[g])
      );
   end

   // Registered from the cells' next-edge terms so it lands on the same edge as rise/fall.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_changed <= 1'b0;
      else       r_changed <= |w_edge_nxt;
   end

   assign bus.out_o     = w_out;
   assign bus.rise_o    = w_rise;
   assign bus.fall_o    = w_fall;
   assign bus.changed_o = r_changed;

endmodule
